// File: rtl/motors_ctrl_if.sv
// rtl/motors_ctrl_if.sv - motors control command/step interface between opcode handlers and executor
interface motors_ctrl_if #(
   parameter int PULSE_NUM_WIDTH = 16
) ();
   logic                       trigger;
   logic [PULSE_NUM_WIDTH-1:0] pulse_num_x;
   logic [PULSE_NUM_WIDTH-1:0] pulse_num_y;
   logic                       servo_pos;
   logic                       rdy;
   logic                       done;
   logic                       step_x;
   logic                       step_y;
   logic                       dir_x;
   logic                       dir_y;
   logic                       servo_out;

   modport master (
      output trigger, pulse_num_x, pulse_num_y, servo_pos,
      input  rdy, done, step_x, step_y, dir_x, dir_y, servo_out
   );

   modport slave (
      input  trigger, pulse_num_x, pulse_num_y, servo_pos,
      output rdy, done, step_x, step_y, dir_x, dir_y, servo_out
   );
endinterface

// File: rtl/motors_ctrl_executor.sv
// rtl/motors_ctrl_executor.sv - pen servo move/settle then paced X/Y step-dir pulse generation
module motors_ctrl_executor #(
   parameter int PULSE_NUM_WIDTH    = 16,
   parameter int SERVO_SETTLE_TICKS = 50000
) (
   input logic         clk,
   input logic         reset,
   input logic         clk_en,
   motors_ctrl_if.slave ctrl
);
   localparam int W  = PULSE_NUM_WIDTH;
   localparam int CW = $clog2(SERVO_SETTLE_TICKS + 1);
   localparam logic [W-1:0]  ONE         = 1;
   localparam logic [CW-1:0] CNT_ONE     = 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SERVO_SETTLE_TICKS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_STEP   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  rem_x_q, rem_x_d;
   logic [W-1:0]  rem_y_q, rem_y_d;
   logic          step_x_q, step_x_d;
   logic          step_y_q, step_y_d;
   logic          dir_x_q, dir_x_d;
   logic          dir_y_q, dir_y_d;
   logic          servo_q, servo_d;
   logic [CW-1:0] settle_cnt_q, settle_cnt_d;
   logic [W-1:0]  abs_x, abs_y;

   // Two's-complement magnitude; the most negative value maps to 2^(W-1) as unsigned
   assign abs_x = ctrl.pulse_num_x[W-1] ? (~ctrl.pulse_num_x + ONE) : ctrl.pulse_num_x;
   assign abs_y = ctrl.pulse_num_y[W-1] ? (~ctrl.pulse_num_y + ONE) : ctrl.pulse_num_y;

   // State and datapath registers; reset abandons any command in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         rem_x_q      <= '0;
         rem_y_q      <= '0;
         step_x_q     <= 1'b0;
         step_y_q     <= 1'b0;
         dir_x_q      <= 1'b0;
         dir_y_q      <= 1'b0;
         servo_q      <= 1'b0;
         settle_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         rem_x_q      <= rem_x_d;
         rem_y_q      <= rem_y_d;
         step_x_q     <= step_x_d;
         step_y_q     <= step_y_d;
         dir_x_q      <= dir_x_d;
         dir_y_q      <= dir_y_d;
         servo_q      <= servo_d;
         settle_cnt_q <= settle_cnt_d;
      end
   end

   // Next-state: accept in IDLE, wait out servo settle, then run both axes until drained
   always_comb begin
      state_d      = state_q;
      rem_x_d      = rem_x_q;
      rem_y_d      = rem_y_q;
      step_x_d     = step_x_q;
      step_y_d     = step_y_q;
      dir_x_d      = dir_x_q;
      dir_y_d      = dir_y_q;
      servo_d      = servo_q;
      settle_cnt_d = settle_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (ctrl.trigger) begin
               rem_x_d      = abs_x;
               rem_y_d      = abs_y;
               dir_x_d      = ~ctrl.pulse_num_x[W-1];
               dir_y_d      = ~ctrl.pulse_num_y[W-1];
               servo_d      = ctrl.servo_pos;
               step_x_d     = 1'b0;
               step_y_d     = 1'b0;
               settle_cnt_d = '0;
               state_d      = (ctrl.servo_pos != servo_q) ? S_SETTLE : S_STEP;
            end
         end
         S_SETTLE: begin
            if (clk_en) begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  settle_cnt_d = '0;
                  state_d      = S_STEP;
               end else begin
                  settle_cnt_d = settle_cnt_q + CNT_ONE;
               end
            end
         end
         S_STEP: begin
            // Completion is checked every clk; stepping only advances on clk_en ticks
            if (rem_x_q == '0 && rem_y_q == '0 && !step_x_q && !step_y_q) begin
               state_d = S_DONE;
            end else if (clk_en) begin
               if (step_x_q) begin
                  step_x_d = 1'b0;
                  rem_x_d  = rem_x_q - ONE;
               end else if (rem_x_q != '0) begin
                  step_x_d = 1'b1;
               end
               if (step_y_q) begin
                  step_y_d = 1'b0;
                  rem_y_d  = rem_y_q - ONE;
               end else if (rem_y_q != '0) begin
                  step_y_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ctrl.rdy       = (state_q == S_IDLE);
   assign ctrl.done      = (state_q == S_DONE);
   assign ctrl.step_x    = step_x_q;
   assign ctrl.step_y    = step_y_q;
   assign ctrl.dir_x     = dir_x_q;
   assign ctrl.dir_y     = dir_y_q;
   assign ctrl.servo_out = servo_q;
endmodule

// File: tb/tb_motors_ctrl_executor.sv
// tb/tb_motors_ctrl_executor.sv - randomized command-level check of motors_ctrl_executor
module tb_motors_ctrl_executor;
   localparam int W  = 8;
   localparam int ST = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic clk_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   model_servo = 1'b0;

   always #5 clk = ~clk;

   motors_ctrl_if #(.PULSE_NUM_WIDTH(W)) bus ();

   motors_ctrl_executor #(
      .PULSE_NUM_WIDTH(W),
      .SERVO_SETTLE_TICKS(ST)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clk_en(clk_en),
      .ctrl(bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // One command: p = clk_en period (0 = clk_en held low); inject = pulse a second trigger mid-command
   task automatic run_cmd(input int x, input int y, input bit sv, input int p, input bit inject);
      int  px = 0, py = 0, hx = 0, hy = 0, wbad = 0;
      int  ticks = 0, first_ticks = -1, done_cnt = 0, done_i = 0, last_fall = 0, rdy_after = -1;
      int  i = 0;
      bit  changed;
      bit  prev_sx = 1'b0, prev_sy = 1'b0, en;
      while (!bus.rdy && i < 100) begin
         cyc();
         i++;
      end
      check_eq("rdy_before_cmd", bus.rdy, 1);
      changed         = (sv != model_servo);
      bus.pulse_num_x = W'(x);
      bus.pulse_num_y = W'(y);
      bus.servo_pos   = sv;
      bus.trigger     = 1'b1;
      clk_en          = 1'b0;
      cyc();
      bus.trigger     = 1'b0;
      model_servo     = sv;
      check_eq("rdy_after_accept", bus.rdy, 0);
      check_eq("servo_out", bus.servo_out, sv);
      check_eq("dir_x", bus.dir_x, (x >= 0));
      check_eq("dir_y", bus.dir_y, (y >= 0));
      bus.pulse_num_x = W'($urandom);
      bus.pulse_num_y = W'($urandom);
      bus.servo_pos   = 1'($urandom);
      for (i = 1; i <= 3000 && !(done_i > 0 && i > done_i + 3); i++) begin
         en     = (p > 0) && ((i % p) == 0);
         clk_en = en;
         if (inject && i == 6) begin
            bus.trigger     = 1'b1;
            bus.pulse_num_x = W'(100);
         end else begin
            bus.trigger = 1'b0;
         end
         cyc();
         if (first_ticks < 0) begin
            if ((bus.step_x && !prev_sx) || (bus.step_y && !prev_sy) || bus.done)
               first_ticks = ticks;
            else if (en)
               ticks++;
         end
         if (bus.step_x && !prev_sx) px++;
         if (bus.step_y && !prev_sy) py++;
         if (bus.step_x) hx++;
         if (bus.step_y) hy++;
         if (!bus.step_x && prev_sx) begin
            if (hx != p) wbad++;
            hx = 0;
            last_fall = i;
         end
         if (!bus.step_y && prev_sy) begin
            if (hy != p) wbad++;
            hy = 0;
            last_fall = i;
         end
         if (bus.done) begin
            done_cnt++;
            if (done_i == 0) done_i = i;
         end
         if (done_i > 0 && i == done_i + 1) rdy_after = bus.rdy;
         prev_sx = bus.step_x;
         prev_sy = bus.step_y;
      end
      bus.trigger = 1'b0;
      check_eq("done_count", done_cnt, 1);
      check_eq("pulses_x", px, iabs(x));
      check_eq("pulses_y", py, iabs(y));
      check_eq("pulse_width_bad", wbad, 0);
      check_eq("settle_ticks", first_ticks, changed ? ST : 0);
      check_eq("rdy_after_done", rdy_after, 1);
      check_eq("dir_x_stable", bus.dir_x, (x >= 0));
      check_eq("servo_stable", bus.servo_out, sv);
      if (iabs(x) + iabs(y) > 0)
         check_eq("done_after_last_fall", done_i, last_fall + 1);
      else if (!changed)
         check_eq("zero_cmd_done_n2", done_i, 1);
   endtask

   initial begin
      int x, y, p;
      bit sv;
      int cnt;
      bus.trigger     = 1'b0;
      bus.pulse_num_x = '0;
      bus.pulse_num_y = '0;
      bus.servo_pos   = 1'b0;
      repeat (3) cyc();
      reset = 1'b1;
      cyc();
      check_eq("reset_rdy", bus.rdy, 1);
      check_eq("reset_done", bus.done, 0);
      check_eq("reset_steps", {bus.step_x, bus.step_y}, 0);
      check_eq("reset_servo", bus.servo_out, 0);
      check_eq("reset_dirs", {bus.dir_x, bus.dir_y}, 0);

      run_cmd(3, -2, 1'b0, 4, 1'b0);
      run_cmd(0, 0, 1'b1, 2, 1'b0);
      run_cmd(0, 0, 1'b1, 0, 1'b0);
      run_cmd(2, 1, 1'b1, 2, 1'b1);
      run_cmd(-128, 127, 1'b1, 1, 1'b0);

      for (int k = 0; k < 12; k++) begin
         x  = int'($urandom_range(0, 12)) - 6;
         y  = int'($urandom_range(0, 12)) - 6;
         if ($urandom_range(0, 3) == 0) begin
            x = 0;
            y = 0;
         end
         sv = 1'($urandom_range(0, 1));
         p  = int'($urandom_range(1, 4));
         run_cmd(x, y, sv, p, 1'b0);
      end

      // trigger held high: back-to-back zero commands
      bus.pulse_num_x = '0;
      bus.pulse_num_y = '0;
      bus.servo_pos   = model_servo;
      clk_en          = 1'b0;
      bus.trigger     = 1'b1;
      cyc();
      cyc();
      check_eq("held_done_1", bus.done, 1);
      cyc();
      check_eq("held_rdy", bus.rdy, 1);
      cyc();
      check_eq("held_reaccept", bus.rdy, 0);
      cyc();
      check_eq("held_done_2", bus.done, 1);
      bus.trigger = 1'b0;
      repeat (3) cyc();

      // reset in the middle of a long command
      bus.pulse_num_x = W'(-128);
      bus.pulse_num_y = W'(127);
      bus.servo_pos   = model_servo;
      bus.trigger     = 1'b1;
      clk_en          = 1'b1;
      cyc();
      bus.trigger = 1'b0;
      repeat (40) cyc();
      #2;
      reset = 1'b0;
      #1;
      check_eq("midrst_steps", {bus.step_x, bus.step_y}, 0);
      check_eq("midrst_rdy", bus.rdy, 1);
      check_eq("midrst_done", bus.done, 0);
      cyc();
      cyc();
      reset = 1'b1;
      model_servo = 1'b0;
      cyc();
      check_eq("postrst_rdy", bus.rdy, 1);
      check_eq("postrst_servo", bus.servo_out, 0);
      check_eq("postrst_dirs", {bus.dir_x, bus.dir_y}, 0);
      cnt = 0;
      for (int k = 0; k < 300; k++) begin
         cyc();
         if (bus.done || bus.step_x || bus.step_y) cnt++;
      end
      check_eq("postrst_quiet", cnt, 0);
      run_cmd(1, -1, 1'b0, 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
